// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Blanked slot dead-time, per-digit enable/blink, frame-synchronous double buffering.
module seg_scan_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              bcd,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SLOT    = CLK_FREQ / SCAN_HZ;
  localparam int HALF    = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SLOT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT - 1);
  localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slotCnt_q, slotCnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_W-1:0]      blinkCnt_q, blinkCnt_d;
  logic                    blinkPhase_q, blinkPhase_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   pendingDp_q, pendingDp_d;
  logic                    pendingFlag_q, pendingFlag_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frameDone_q, frameDone_d;
  logic                    lastSlot, wrap, blinkEnd, lit;

  always_comb begin
    lastSlot      = (slotCnt_q == SLOT_LAST);
    wrap          = lastSlot && (idx_q == IDX_LAST);
    slotCnt_d     = lastSlot ? '0 : slotCnt_q + 1'b1;
    idx_d         = idx_q;
    if (lastSlot) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d       = (slotCnt_d < BLANK_END) ? BLANK : SHOW;

    blinkEnd      = (blinkCnt_q == BLINK_LAST);
    blinkCnt_d    = blinkEnd ? '0 : blinkCnt_q + 1'b1;
    blinkPhase_d  = blinkPhase_q ^ blinkEnd;

    // Outputs follow the slot state one cycle later; bcd pre-settles during BLANK.
    lit           = (state_q == SHOW) && digit_en[idx_q] && !(blink_mask[idx_q] && blinkPhase_q);
    an_d          = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    bcd_d         = shadow_q[{idx_q, 2'b00} +: 4];
    dp_d          = lit && shadowDp_q[idx_q];
    frameDone_d   = wrap;

    shadow_d      = shadow_q;
    shadowDp_d    = shadowDp_q;
    pending_d     = pending_q;
    pendingDp_d   = pendingDp_q;
    pendingFlag_d = pendingFlag_q;
    if (wrap) begin
      if (pendingFlag_q) begin
        shadow_d   = pending_q;
        shadowDp_d = pendingDp_q;
      end
      pendingFlag_d = 1'b0;
    end
    // A load on the wrap cycle lands in pending after the old pending moved to shadow.
    if (load) begin
      pending_d     = digits_in;
      pendingDp_d   = dp_in;
      pendingFlag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      slotCnt_q     <= '0;
      idx_q         <= '0;
      blinkCnt_q    <= '0;
      blinkPhase_q  <= 1'b0;
      pending_q     <= '0;
      pendingDp_q   <= '0;
      pendingFlag_q <= 1'b0;
      shadow_q      <= '0;
      shadowDp_q    <= '0;
      bcd_q         <= '0;
      dp_q          <= 1'b0;
      an_q          <= '0;
      frameDone_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slotCnt_q     <= slotCnt_d;
      idx_q         <= idx_d;
      blinkCnt_q    <= blinkCnt_d;
      blinkPhase_q  <= blinkPhase_d;
      pending_q     <= pending_d;
      pendingDp_q   <= pendingDp_d;
      pendingFlag_q <= pendingFlag_d;
      shadow_q      <= shadow_d;
      shadowDp_q    <= shadowDp_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frameDone_q   <= frameDone_d;
    end
  end

  assign bcd        = bcd_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle reference model plus a
// table of hand-computed spot vectors and directed reset/load sequences.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] digitsIn;
  logic [7:0]  dpIn;
  logic [7:0]  digitEn;
  logic [7:0]  blinkMask;
  logic [3:0]  bcd;
  logic        dp;
  logic [7:0]  an;
  logic        frameDone;

  seg_scan_ctrl #(
    .CLK_FREQ  (80),
    .SCAN_HZ   (10),
    .BLANK_CYC (2),
    .BLINK_HZ  (1),
    .NUM_DIGITS(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digitsIn),
    .dp_in     (dpIn),
    .load      (load),
    .digit_en  (digitEn),
    .blink_mask(blinkMask),
    .bcd       (bcd),
    .dp        (dp),
    .an        (an),
    .frame_done(frameDone)
  );

  typedef struct {
    int         seg;
    int         n;
    logic [7:0] an;
    logic [3:0] bcd;
    logic       dp;
    logic       fd;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          passed = 0;
  int          n = 0;
  int          seg = 0;
  int          lastFd = -1;
  logic [31:0] pendM, shadowM;
  logic [7:0]  pendDpM, shadowDpM;
  logic        pendFlagM;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s seg=%0d cycle=%0d actual=%0h required=%0h", name, seg, n, act, exp);
  endtask

  task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [7:0] dpv,
                               input logic [7:0] en, input logic [7:0] mask);
    load      = ld;
    digitsIn  = d;
    dpIn      = dpv;
    digitEn   = en;
    blinkMask = mask;
  endtask

  task automatic resetModel();
    n         = 0;
    lastFd    = -1;
    pendM     = '0;
    pendDpM   = '0;
    pendFlagM = 1'b0;
    shadowM   = '0;
    shadowDpM = '0;
  endtask

  // One clock: expectation from pre-edge model state, then sample 1 time unit after the edge.
  task automatic tick();
    int         m, pos, k;
    logic       ph, lit, expDp, expFd;
    logic [7:0] expAn;
    logic [3:0] expBcd;
    m      = n;
    pos    = m % 8;
    k      = (m / 8) % 8;
    ph     = ((m / 40) % 2) == 1;
    lit    = (pos >= 2) && digitEn[k] && !(blinkMask[k] && ph);
    expAn  = lit ? (8'h01 << k) : 8'h00;
    expBcd = shadowM[k*4 +: 4];
    expDp  = lit && shadowDpM[k];
    expFd  = (m % 64) == 63;
    @(posedge clk);
    n++;
    if (n % 64 == 0) begin
      if (pendFlagM) begin
        shadowM   = pendM;
        shadowDpM = pendDpM;
      end
      pendFlagM = 1'b0;
    end
    if (load) begin
      pendM     = digitsIn;
      pendDpM   = dpIn;
      pendFlagM = 1'b1;
    end
    #1;
    checkOutput("model_an", an, expAn);
    checkOutput("model_bcd", bcd, expBcd);
    checkOutput("model_dp", dp, expDp);
    checkOutput("model_frame_done", frameDone, expFd);
    checkOutput("an_onehot0", $onehot0(an), 1);
    if (frameDone === 1'b1) begin
      if (lastFd >= 0) checkOutput("frame_period", n - lastFd, 64);
      lastFd = n;
    end
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].seg == seg && tbl[i].n == n) begin
        checkOutput("vec_an", an, tbl[i].an);
        checkOutput("vec_bcd", bcd, tbl[i].bcd);
        checkOutput("vec_dp", dp, tbl[i].dp);
        checkOutput("vec_frame_done", frameDone, tbl[i].fd);
      end
    end
    load = 1'b0;
  endtask

  task automatic runTo(input int target);
    while (n < target) tick();
  endtask

  initial begin
    // Hand-computed spot vectors: {segment, cycle after reset release, an, bcd, dp, frame_done}
    tbl.push_back('{0,   1, 8'h00, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,   3, 8'h01, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,   8, 8'h01, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,   9, 8'h00, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,  11, 8'h02, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,  64, 8'h80, 4'h0, 1'b0, 1'b1});
    tbl.push_back('{0,  65, 8'h00, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0,  83, 8'h04, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{0, 129, 8'h00, 4'h1, 1'b0, 1'b0});
    tbl.push_back('{0, 131, 8'h01, 4'h1, 1'b0, 1'b0});
    tbl.push_back('{0, 145, 8'h00, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{0, 147, 8'h04, 4'h3, 1'b1, 1'b0});
    tbl.push_back('{0, 171, 8'h20, 4'h6, 1'b0, 1'b0});
    tbl.push_back('{0, 192, 8'h80, 4'h8, 1'b0, 1'b1});
    tbl.push_back('{0, 195, 8'h01, 4'h2, 1'b1, 1'b0});
    tbl.push_back('{0, 259, 8'h00, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{0, 267, 8'h02, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{0, 331, 8'h02, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{0, 395, 8'h00, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{0, 684, 8'h20, 4'h3, 1'b0, 1'b0});
    tbl.push_back('{1,   3, 8'h01, 4'h0, 1'b0, 1'b0});
    tbl.push_back('{1,  64, 8'h80, 4'h0, 1'b0, 1'b1});
    tbl.push_back('{1,  67, 8'h01, 4'h0, 1'b0, 1'b0});

    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_an", an, 8'h00);
    checkOutput("reset_bcd", bcd, 4'h0);
    checkOutput("reset_dp", dp, 1'b0);
    checkOutput("reset_frame_done", frameDone, 1'b0);
    resetModel();
    seg = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load mid-frame 1; shows from frame 2.
    runTo(69);
    applyStimulus(1'b1, 32'h8765_4321, 8'h04, 8'hFF, 8'h00);
    tick();

    // Two loads before a wrap, then one coincident with the wrap at cycle 192.
    runTo(139);
    applyStimulus(1'b1, 32'h1111_1111, 8'hFF, 8'hFF, 8'h00);
    tick();
    runTo(149);
    applyStimulus(1'b1, 32'h2222_2222, 8'h01, 8'hFF, 8'h00);
    tick();
    runTo(191);
    applyStimulus(1'b1, 32'h3333_3333, 8'h00, 8'hFF, 8'h00);
    tick();

    // Digit 0 disabled, digit 1 blinking; free-run through frame 10.
    runTo(256);
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFE, 8'h02);
    runTo(669);
    applyStimulus(1'b1, 32'h9999_9999, 8'hFF, 8'hFE, 8'h02);
    tick();
    runTo(684);

    // Asynchronous reset during SHOW of slot 5, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_an", an, 8'h00);
    checkOutput("async_reset_bcd", bcd, 4'h0);
    checkOutput("async_reset_dp", dp, 1'b0);
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    @(negedge clk);
    resetModel();
    seg = 1;
    rst_n = 1'b1;

    // Pending 9s must be lost: two full frames of zeros.
    runTo(130);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit seven-segment display.
- Selects one digit per scan slot and presents its 4-bit code to the BCD_to_SEG decoder, plus the matching one-hot digit enable and decimal point.
- Applies blanking dead-time between slots, per-digit enable and blink, and frame-synchronous double-buffered loading of display data.
- Sits between the car-simulation status logic (mileage, state codes) and the display pins.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, slot rate in Hz; slot length SLOT = CLK_FREQ/SCAN_HZ cycles.
- BLANK_CYC, 1000, dead-time cycles at the start of each slot; must be less than SLOT.
- BLINK_HZ, 2, blink rate; blink phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles.
- NUM_DIGITS, 8, number of digits scanned.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- digits_in, input, 4*NUM_DIGITS, digit codes; digit i is bits [4i+3:4i].
- dp_in, input, NUM_DIGITS, decimal-point request per digit.
- load, input, 1, single-cycle strobe; captures digits_in/dp_in into the pending buffer.
- digit_en, input, NUM_DIGITS, live per-digit enable; 0 keeps that slot dark.
- blink_mask, input, NUM_DIGITS, live per-digit blink select.
- bcd, output, 4, code for the current digit, fed to BCD_to_SEG.
- dp, output, 1, decimal point for the current digit, active-high.
- an, output, NUM_DIGITS, one-hot digit enable, active-high.
- frame_done, output, 1, one-cycle pulse at the end of the last slot.

Behaviour:
- Clock and reset:
  - Single clock domain; rst_n is asynchronous assert, synchronous deassert (synchronised upstream). All registers reset.
- Reset values:
  - bcd=0, dp=0, an=0, frame_done=0.
  - Slot index=0, slot counter=0, state=BLANK, blink phase=0, blink counter=0.
  - Shadow and pending buffers = 0; pending flag = 0.
- Slot state machine:
  - BLANK: an=0 for cycles 0..BLANK_CYC-1 of the slot.
  - SHOW: cycles BLANK_CYC..SLOT-1.
  - At slot counter SLOT-1: counter goes to 0, index increments (wraps NUM_DIGITS-1 to 0), state goes to BLANK.
  - Slot length is constant regardless of digit_en or blink.
- SHOW outputs for index k:
  - an=(1<<k) if digit_en[k] && !(blink_mask[k] && blink_phase), else an=0.
  - bcd=shadow[k]; dp=shadow_dp[k] only when an!=0, else dp=0.
- Output timing and latency:
  - bcd, dp and an are registered and change on the same edge.
  - Latency from a slot-counter boundary to output change: 1 cycle.
  - During BLANK, bcd already holds the new digit's code (pre-settle).
- frame_done:
  - Asserted for exactly one cycle, on the cycle after index NUM_DIGITS-1 finishes SHOW, coincident with index becoming 0.
- Double buffering:
  - load copies digits_in/dp_in into pending and sets the pending flag.
  - The shadow buffer updates from pending only at the frame wrap (index NUM_DIGITS-1 to 0); the flag then clears.
  - Display never shows a mix of two loads within one frame.
  - load repeated before a wrap: last value wins.
  - load on the same cycle as the wrap: the previous pending is transferred, the new value is pending for the next frame.
- Blink:
  - Free-running counter; phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles, independent of the scan.
  - Phase 1 darkens masked digits; codes are retained.
- Live inputs:
  - digit_en and blink_mask are sampled every cycle; a change takes effect on the next registered update inside the current slot.
- Reset mid-operation:
  - All outputs go to reset values immediately (asynchronous).
  - Pending data is lost; scanning restarts at index 0 in BLANK.
- Arithmetic and widths:
  - Counter widths use $clog2 of SLOT and the blink half-period; index width is $clog2(NUM_DIGITS).
  - No overflow beyond the terminal count.

Test Plan:
Bench parameters: CLK_FREQ=80, SCAN_HZ=10 (SLOT=8), BLANK_CYC=2, BLINK_HZ=1 (phase toggles every 40 cycles), NUM_DIGITS=8.

1. Reset, then hold rst_n=1 for 64 cycles with digit_en=8'hFF and no load -> an is 0 for 2 cycles then one-hot for 6 cycles per slot, sequencing 01,02,...,80. bcd=0 throughout; frame_done pulses at cycle 64.
2. load digits_in=32'h8765_4321, dp_in=8'h04 mid-frame -> display still shows 0s until the wrap. The next frame shows bcd=1..8 for slots 0..7; dp=1 only while an=8'h04.
3. Two loads before a wrap (32'h1111_1111, then 32'h2222_2222), plus a load coincident with the wrap -> the next frame shows all 2s; the coincident value appears one frame later.
4. digit_en=8'hFE, blink_mask=8'h02 -> slot 0 has an=0 for its full 8 cycles. Slot 1 shows an=8'h02 while phase=0 and an=0 while phase=1, toggling every 40 cycles. Slot timing is unchanged.
5. Assert rst_n=0 during SHOW of slot 5 -> an=0, bcd=0, dp=0 in the same cycle without waiting for an edge. After release the scan restarts at slot 0 BLANK and the shadow buffer reads 0.
6. Free-run 10 frames -> frame_done pulses are exactly 64 cycles apart and each is 1 cycle wide. an is never multi-hot and is never nonzero during BLANK cycles.
